// File: rtl/pingpong_width_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_pkg
//  Brief    : Shared types and width helpers for the ping-pong width converter.
//  Revision : 1.0  initial release
// ============================================================================
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    // Never returns zero so single-entry counters still get a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rd_addr_w(input int wr_num, input int ratio);
        return cnt_w(wr_num / ratio);
    endfunction

    function automatic int pack_cnt_w(input int ratio);
        return cnt_w(ratio);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pingpong_width_conv_if.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_width_conv_if
//  Brief    : Input strobe bus and framed valid/ready output bus.
//  Revision : 1.0  initial release
// ============================================================================
interface pingpong_width_conv_if #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 64
);
    logic              valid_in;
    logic [DIN_W-1:0]  data_in;
    logic              valid_out;
    logic              ready_out;
    logic [DOUT_W-1:0] data_out;
    logic              sop_out;
    logic              eop_out;

    modport master (
        output valid_in, data_in, ready_out,
        input  valid_out, data_out, sop_out, eop_out
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output valid_out, data_out, sop_out, eop_out
    );
endinterface
`default_nettype wire

// File: rtl/pingpong_width_conv_skid.sv
`default_nettype none
// ============================================================================
//  Module   : ppbuf_skid
//  Brief    : 2-entry output skid buffer carrying {sop,eop,data}; credit_o
//             tells the RAM reader whether one more read may be launched.
//  Revision : 1.0  initial release
// ============================================================================
module ppbuf_skid #(
    parameter int W = 64
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          in_valid_i,
    input  wire          in_sop_i,
    input  wire          in_eop_i,
    input  wire [W-1:0]  in_data_i,
    output logic         credit_o,
    output logic         out_valid_o,
    input  wire          out_ready_i,
    output logic         out_sop_o,
    output logic         out_eop_o,
    output logic [W-1:0] out_data_o
);
    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [W-1:0] data;
    } entry_t;

    entry_t     e0_q, e1_q, w_in;
    logic [1:0] cnt_q;
    logic [2:0] w_next_cnt;
    logic       w_pop;

    assign w_in        = {in_sop_i, in_eop_i, in_data_i};
    assign out_valid_o = (cnt_q != 2'd0);
    assign w_pop       = out_valid_o && out_ready_i;
    assign out_sop_o   = out_valid_o && e0_q.sop;
    assign out_eop_o   = out_valid_o && e0_q.eop;
    assign out_data_o  = e0_q.data;

    // A read launched now lands here two edges later and is pushed unconditionally,
    // so it may only go out if at most one slot is taken after this edge.
    assign w_next_cnt = {1'b0, cnt_q} + {2'b00, in_valid_i} - {2'b00, w_pop};
    assign credit_o   = (w_next_cnt <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            case ({in_valid_i, w_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= w_in;
                    else               e1_q <= w_in;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= w_in;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/pingpong_width_conv.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_width_conv
//  Brief    : Two-bank ping-pong buffer packing RATIO input words per output
//             word; each full bank leaves as one sop/eop framed burst.
//             Optional feature macro: PPBUF_OVF_CNT_EN (saturating ovf_cnt port).
//  Revision : 1.0  initial release
// ============================================================================
module pingpong_width_conv
    import pingpong_pkg::*;
#(
    parameter int DIN_W  = 32,
    parameter int RATIO  = 2,
    parameter int WR_NUM = 512
) (
    input  wire                  clk,
    input  wire                  rst_n,
    pingpong_width_conv_if.slave bus,
    output logic                 ovf_out
`ifdef PPBUF_OVF_CNT_EN
    ,
    output logic [15:0]          ovf_cnt
`endif
);
    localparam int DOUT_W = DIN_W * RATIO;
    localparam int RD_NUM = WR_NUM / RATIO;
    localparam int AW     = rd_addr_w(WR_NUM, RATIO);
    localparam int PW     = pack_cnt_w(RATIO);
    localparam int IW     = AW + 1;

    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];

    logic              wr_sel_q;
    logic [AW-1:0]     wr_addr_q;
    logic [PW-1:0]     pack_cnt_q;
    logic              ovf_q;
    logic              w_wr_ok, w_accept, w_pack_done, w_wr_last, w_ram_we;
    logic [DOUT_W-1:0] w_wr_word;
    logic [IW-1:0]     w_wr_idx, w_rd_idx;

    rd_state_e         rd_state_q, rd_state_d;
    logic              rd_sel_q, rd_sel_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              w_issue, w_rd_last, w_credit;
    logic              rv_q, rsop_q, reop_q;
    logic [DOUT_W-1:0] rdata_q;

    logic [DOUT_W-1:0] mem_q [2*RD_NUM];

    assign w_wr_ok     = (bank_q[wr_sel_q] == EMPTY) || (bank_q[wr_sel_q] == FILLING);
    assign w_accept    = bus.valid_in && w_wr_ok;
    assign w_pack_done = (pack_cnt_q == PW'(RATIO - 1));
    assign w_wr_last   = w_pack_done && (wr_addr_q == AW'(RD_NUM - 1));
    assign w_ram_we    = w_accept && w_pack_done;
    assign w_rd_last   = (rd_addr_q == AW'(RD_NUM - 1));
    assign ovf_out     = ovf_q;

    // Bank 1 occupies the upper RD_NUM entries whether or not RD_NUM is a power of 2.
    assign w_wr_idx = {1'b0, wr_addr_q} + (wr_sel_q ? IW'(RD_NUM) : IW'(0));
    assign w_rd_idx = {1'b0, rd_addr_q} + (rd_sel_q ? IW'(RD_NUM) : IW'(0));

    generate
        if (RATIO > 1) begin : g_pack
            logic [DOUT_W-DIN_W-1:0] pack_q;
            logic [DOUT_W-1:0]       w_cat;

            // Oldest word drifts toward the LSBs as newer words enter at the top.
            assign w_cat     = {bus.data_in, pack_q};
            assign w_wr_word = w_cat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        pack_q <= '0;
                else if (w_accept) pack_q <= w_cat[DOUT_W-1:DIN_W];
            end
        end else begin : g_bypass
            assign w_wr_word = bus.data_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            pack_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= bus.valid_in && !w_wr_ok;
            if (w_accept) begin
                if (w_pack_done) begin
                    pack_cnt_q <= '0;
                    if (w_wr_last) begin
                        wr_addr_q <= '0;
                        wr_sel_q  <= ~wr_sel_q;
                    end else begin
                        wr_addr_q <= wr_addr_q + AW'(1);
                    end
                end else begin
                    pack_cnt_q <= pack_cnt_q + PW'(1);
                end
            end
        end
    end

`ifdef PPBUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt_q <= 16'd0;
        else if (bus.valid_in && !w_wr_ok && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (w_ram_we) mem_q[w_wr_idx] <= w_wr_word;
    end

    always_ff @(posedge clk) begin
        if (w_issue) rdata_q <= mem_q[w_rd_idx];
    end

    // Writer only touches EMPTY/FILLING banks and the reader only FULL/READING
    // ones, so the two updates below never land on the same bank.
    always_comb begin
        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_addr_d  = rd_addr_q;
        w_issue    = 1'b0;

        if (w_accept) bank_d[wr_sel_q] = w_wr_last ? FULL : FILLING;

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_q[rd_sel_q] == FULL) rd_state_d = RD_RUN;
            end
            RD_RUN: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_rd_last) begin
                        bank_d[rd_sel_q] = EMPTY;
                        rd_sel_d         = ~rd_sel_q;
                        rd_addr_d        = '0;
                        rd_state_d       = (bank_q[~rd_sel_q] == FULL) ? RD_RUN : RD_IDLE;
                    end else begin
                        bank_d[rd_sel_q] = READING;
                        rd_addr_d        = rd_addr_q + AW'(1);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= EMPTY;
            bank_q[1]  <= EMPTY;
            rd_state_q <= RD_IDLE;
            rd_sel_q   <= 1'b0;
            rd_addr_q  <= '0;
            rv_q       <= 1'b0;
            rsop_q     <= 1'b0;
            reop_q     <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            rd_state_q <= rd_state_d;
            rd_sel_q   <= rd_sel_d;
            rd_addr_q  <= rd_addr_d;
            rv_q       <= w_issue;
            rsop_q     <= w_issue && (rd_addr_q == '0);
            reop_q     <= w_issue && w_rd_last;
        end
    end

    ppbuf_skid #(
        .W (DOUT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rv_q),
        .in_sop_i    (rsop_q),
        .in_eop_i    (reop_q),
        .in_data_i   (rdata_q),
        .credit_o    (w_credit),
        .out_valid_o (bus.valid_out),
        .out_ready_i (bus.ready_out),
        .out_sop_o   (bus.sop_out),
        .out_eop_o   (bus.eop_out),
        .out_data_o  (bus.data_out)
    );
endmodule
`default_nettype wire
